fx2_out_ep: RTL and testbench

Parametrised multi-packet model of an FX2 slave-FIFO OUT (host->device) endpoint for the timetag simulation bench. A "host" side writes words and commits them as packets. The FPGA side reads committed words first-word-fall-through via fifoadr/rd. Unlike the single-buffer model, it supports configurable data width, buffer depth, several queued packets, a programmable-level flag, and sticky error flags. It sits on the FD bus alongside the IN endpoint models.

---
 rtl/fx2_pkg.sv | 23 ++
 rtl/fx2_len_queue.sv | 57 +++++
 rtl/fx2_out_ep.sv | 122 ++++++++++++
 tb/tb_fx2_out_ep.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared constants and width helpers for the FX2 slave-FIFO endpoint models.
//   FX2_EPx      : fifoadr encodings of the four FX2 FIFO endpoints
//   clog2(n)     : address width for n entries (minimum 1)
//   cnt_width(n) : width of a counter that must hold the value n itself
package fx2_pkg;

  localparam logic [1:0] FX2_EP2 = 2'd0;
  localparam logic [1:0] FX2_EP4 = 2'd1;
  localparam logic [1:0] FX2_EP6 = 2'd2;
  localparam logic [1:0] FX2_EP8 = 2'd3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fx2_len_queue.sv
// Small FIFO of committed packet lengths; the head entry is the packet being read.
//   clk, rst_n       : clock, async active-low reset
//   push, push_len   : enqueue a length (accepted when not full, or full with a same-cycle pop)
//   pop              : dequeue the head (ignored when empty)
//   head             : length at the head
//   count/full/empty : occupancy
module fx2_len_queue
  import fx2_pkg::*;
#(
  parameter int unsigned MAX_PKTS = 4,
  parameter int unsigned LW       = 11,
  localparam int unsigned IW      = clog2(MAX_PKTS),
  localparam int unsigned QW      = cnt_width(MAX_PKTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [LW-1:0] push_len,
  input  logic          pop,
  output logic [LW-1:0] head,
  output logic [QW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [LW-1:0] mem [MAX_PKTS];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == QW'(MAX_PKTS));
  assign empty   = (count == '0);
  assign head    = mem[rd_idx];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  // Index and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + IW'(1);
      if (do_pop)  rd_idx <= rd_idx + IW'(1);
      count <= count + QW'(do_push) - QW'(do_pop);
    end
  end

  // Length storage, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_len;
  end

endmodule

// File: rtl/fx2_out_ep.sv
// FX2 slave-FIFO OUT endpoint model: host writes and commits packets, the FPGA
// reads committed words first-word-fall-through.
//   ifclk, reset_n         : clock, async active-low reset
//   fifoadr, rd, data      : device read side (data = word at read pointer)
//   empty, pf              : no committed data / committed words >= PF_LEVEL
//   data_in, data_wr       : host write side
//   data_commit            : close the open packet
//   host_full              : buffer full or packet queue full
//   pkt_done               : pulse after the last word of a packet is read
//   pkts_pending           : committed packets not fully read
//   overflow, underflow    : sticky error flags
module fx2_out_ep
  import fx2_pkg::*;
#(
  parameter logic [1:0]  FIFOADR  = FX2_EP6,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned MAX_PKTS = 4,
  parameter int unsigned PF_LEVEL = 64,
  localparam int unsigned AW      = clog2(DEPTH),
  localparam int unsigned CW      = cnt_width(DEPTH),
  localparam int unsigned QW      = cnt_width(MAX_PKTS)
) (
  input  logic             ifclk,
  input  logic             reset_n,
  input  logic [1:0]       fifoadr,
  input  logic             rd,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             pf,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_wr,
  input  logic             data_commit,
  output logic             host_full,
  output logic             pkt_done,
  output logic [QW-1:0]    pkts_pending,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    open_cnt;
  logic [CW-1:0]    comm_cnt;
  logic [CW-1:0]    rd_in_pkt;   // words already read from the head packet
  logic [CW-1:0]    q_head;
  logic             q_full;
  logic             q_empty;

  logic             addr_hit;
  logic             rd_acc;
  logic             last_rd;
  logic             space;
  logic             wr_acc;
  logic [CW-1:0]    commit_len;
  logic             commit_req;
  logic             commit_acc;

  // Accept decisions, all from registered state plus current strobes
  always_comb begin
    addr_hit   = (fifoadr == FIFOADR);
    rd_acc     = addr_hit && rd && (comm_cnt != '0);
    last_rd    = rd_acc && !q_empty && ((rd_in_pkt + CW'(1)) == q_head);
    space      = (comm_cnt + open_cnt) < CW'(DEPTH);
    wr_acc     = data_wr && space;
    // A word written alongside the commit belongs to the closing packet.
    commit_len = open_cnt + CW'(wr_acc);
    commit_req = data_commit && (commit_len != '0);
    commit_acc = commit_req && (!q_full || last_rd);
  end

  fx2_len_queue #(
    .MAX_PKTS (MAX_PKTS),
    .LW       (CW)
  ) u_len_queue (
    .clk      (ifclk),
    .rst_n    (reset_n),
    .push     (commit_acc),
    .push_len (commit_len),
    .pop      (last_rd),
    .head     (q_head),
    .count    (pkts_pending),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Pointers, counts and status flags
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      open_cnt  <= '0;
      comm_cnt  <= '0;
      rd_in_pkt <= '0;
      pkt_done  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (last_rd)     rd_in_pkt <= '0;
      else if (rd_acc) rd_in_pkt <= rd_in_pkt + CW'(1);
      comm_cnt  <= comm_cnt - CW'(rd_acc) + (commit_acc ? commit_len : '0);
      open_cnt  <= commit_acc ? '0 : (open_cnt + CW'(wr_acc));
      pkt_done  <= last_rd;
      overflow  <= overflow | (data_wr && !space) | (commit_req && !commit_acc);
      underflow <= underflow | (addr_hit && rd && (comm_cnt == '0));
    end
  end

  // Data buffer, contents are don't-care after reset
  always_ff @(posedge ifclk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  assign data      = mem[rd_ptr];
  assign empty     = (comm_cnt == '0);
  assign pf        = (comm_cnt >= CW'(PF_LEVEL));
  assign host_full = ((comm_cnt + open_cnt) == CW'(DEPTH)) || q_full;

endmodule

// File: tb/tb_fx2_out_ep.sv
// Self-checking bench for fx2_out_ep (DEPTH=16, MAX_PKTS=4, PF_LEVEL=8).
// Written words are pushed to a scoreboard queue and popped on each read.
module tb_fx2_out_ep;
  import fx2_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXP  = 4;
  localparam int unsigned PFL   = 8;

  logic       ifclk;
  logic       reset_n;
  logic [1:0] fifoadr;
  logic       rd;
  logic [7:0] data;
  logic       empty;
  logic       pf;
  logic [7:0] data_in;
  logic       data_wr;
  logic       data_commit;
  logic       host_full;
  logic       pkt_done;
  logic [2:0] pkts_pending;
  logic       overflow;
  logic       underflow;

  logic [7:0] sb[$];
  int         n_tests;
  int         n_fail;

  fx2_out_ep #(
    .FIFOADR  (FX2_EP6),
    .WIDTH    (8),
    .DEPTH    (DEPTH),
    .MAX_PKTS (MAXP),
    .PF_LEVEL (PFL)
  ) dut (
    .ifclk        (ifclk),
    .reset_n      (reset_n),
    .fifoadr      (fifoadr),
    .rd           (rd),
    .data         (data),
    .empty        (empty),
    .pf           (pf),
    .data_in      (data_in),
    .data_wr      (data_wr),
    .data_commit  (data_commit),
    .host_full    (host_full),
    .pkt_done     (pkt_done),
    .pkts_pending (pkts_pending),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ifclk);
    #1;
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    data_wr     = 1'b0;
    data_commit = 1'b0;
    rd          = 1'b0;
    fifoadr     = 2'd0;
    data_in     = 8'h00;
    sb.delete();
    repeat (2) @(posedge ifclk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // Host write; keep=1 means the word is expected to be stored
  task automatic wr(input logic [7:0] w, input bit keep, input bit cm);
    data_in     = w;
    data_wr     = 1'b1;
    data_commit = cm;
    if (keep) sb.push_back(w);
    tick();
    data_wr     = 1'b0;
    data_commit = 1'b0;
  endtask

  task automatic commit;
    data_commit = 1'b1;
    tick();
    data_commit = 1'b0;
  endtask

  // One accepted read at the endpoint address, checked against the scoreboard
  task automatic rd_word(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, 32'(data), 32'(exp));
    end
    fifoadr = 2'd2;
    rd      = 1'b1;
    tick();
    rd      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    do_reset();

    // 1: async reset in the middle of a write
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_pf", 32'(pf), 32'd0);
    wr(8'h11, 1'b1, 1'b0);
    wr(8'h22, 1'b1, 1'b1);
    wr(8'h33, 1'b1, 1'b0);
    check("pre_rst_empty", 32'(empty), 32'd0);
    check("pre_rst_pkts", 32'(pkts_pending), 32'd1);
    data_in = 8'h44;
    data_wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_empty", 32'(empty), 32'd1);
    check("async_host_full", 32'(host_full), 32'd0);
    check("async_pkts", 32'(pkts_pending), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_underflow", 32'(underflow), 32'd0);
    check("async_pkt_done", 32'(pkt_done), 32'd0);
    do_reset();

    // 2: single packet, continuous read
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), 1'b1, 1'b0);
    check("t2_empty_before_commit", 32'(empty), 32'd1);
    commit();
    check("t2_empty", 32'(empty), 32'd0);
    check("t2_pkts", 32'(pkts_pending), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t2_pkt_done_low", 32'(pkt_done), 32'd0);
      rd_word("t2_data");
    end
    check("t2_pkt_done", 32'(pkt_done), 32'd1);
    check("t2_empty_after", 32'(empty), 32'd1);
    check("t2_pkts_after", 32'(pkts_pending), 32'd0);
    tick();
    check("t2_pkt_done_pulse", 32'(pkt_done), 32'd0);

    // 3: two queued packets, last word of the second written with the commit
    do_reset();
    wr(8'h10, 1'b1, 1'b0);
    wr(8'h11, 1'b1, 1'b0);
    wr(8'h12, 1'b1, 1'b0);
    commit();
    wr(8'h20, 1'b1, 1'b0);
    wr(8'h21, 1'b1, 1'b1);
    check("t3_pkts", 32'(pkts_pending), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("t3_pkts_step", 32'(pkts_pending), (i < 3) ? 32'd2 : 32'd1);
      check("t3_pkt_done", 32'(pkt_done), (i == 3) ? 32'd1 : 32'd0);
      rd_word("t3_data");
    end
    check("t3_pkt_done_end", 32'(pkt_done), 32'd1);
    check("t3_pkts_end", 32'(pkts_pending), 32'd0);
    check("t3_empty_end", 32'(empty), 32'd1);

    // 4: address mismatch is ignored, read on empty sets underflow
    do_reset();
    wr(8'h55, 1'b1, 1'b0);
    wr(8'h66, 1'b1, 1'b0);
    commit();
    fifoadr = 2'd0;
    rd      = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    check("t4_data_hold", 32'(data), 32'(sb[0]));
    check("t4_pkts_hold", 32'(pkts_pending), 32'd1);
    check("t4_underflow_low", 32'(underflow), 32'd0);
    rd_word("t4_data");
    rd_word("t4_data");
    fifoadr = 2'd2;
    rd      = 1'b1;
    tick();
    rd = 1'b0;
    check("t4_underflow", 32'(underflow), 32'd1);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_pkts", 32'(pkts_pending), 32'd0);
    check("t4_overflow", 32'(overflow), 32'd0);

    // 5: pf threshold, full buffer and dropped write
    do_reset();
    for (int i = 0; i < 7; i++) wr(8'h80 + 8'(i), 1'b1, 1'b0);
    commit();
    check("t5_pf_below", 32'(pf), 32'd0);
    wr(8'h87, 1'b1, 1'b1);
    check("t5_pf_at_level", 32'(pf), 32'd1);
    for (int i = 8; i < 15; i++) wr(8'h80 + 8'(i), 1'b1, 1'b0);
    check("t5_not_full", 32'(host_full), 32'd0);
    wr(8'h8F, 1'b1, 1'b0);
    check("t5_full_open", 32'(host_full), 32'd1);
    commit();
    check("t5_pkts", 32'(pkts_pending), 32'd3);
    check("t5_overflow_low", 32'(overflow), 32'd0);
    wr(8'hEE, 1'b0, 1'b0);
    check("t5_overflow", 32'(overflow), 32'd1);
    check("t5_full", 32'(host_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("t5_pf_drain", 32'(pf), ((16 - i) >= PFL) ? 32'd1 : 32'd0);
      rd_word("t5_data");
    end
    check("t5_empty_end", 32'(empty), 32'd1);
    check("t5_full_end", 32'(host_full), 32'd0);
    check("t5_overflow_sticky", 32'(overflow), 32'd1);

    // 6: queue full rejects a commit; a pop in the same cycle lets it in
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i), 1'b1, 1'b1);
    check("t6_pkts_full", 32'(pkts_pending), 32'd4);
    check("t6_host_full", 32'(host_full), 32'd1);
    wr(8'h50, 1'b1, 1'b0);
    check("t6_overflow_low", 32'(overflow), 32'd0);
    commit();
    check("t6_overflow", 32'(overflow), 32'd1);
    check("t6_pkts_rej", 32'(pkts_pending), 32'd4);
    data_commit = 1'b1;
    rd_word("t6_data");
    data_commit = 1'b0;
    check("t6_pkts_swap", 32'(pkts_pending), 32'd4);
    check("t6_pkt_done", 32'(pkt_done), 32'd1);
    for (int i = 0; i < 4; i++) rd_word("t6_drain");
    check("t6_empty_end", 32'(empty), 32'd1);
    check("t6_pkts_end", 32'(pkts_pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
